hpdcache_wbuf_send_sched: RTL and testbench

Controls the entry lifecycle of the HPDcache write buffer (WBUF) directory.
- Allocates free entries for new write requests.
- Ages open entries with per-entry time counters and promotes them to pending on threshold or flush.
- Schedules one pending entry at a time towards the memory write interface, round-robin, with a valid/ready handshake.
- Frees entries on memory write acknowledge.
Sits between the WBUF directory/data arrays (index consumer) and the memory-request arbiter.

---
 rtl/hpdcache_pkg.sv | 6 +
 rtl/hpdcache_wbuf_send_sched_if.sv | 33 +++
 rtl/hpdcache_rr_pick.sv | 20 ++
 rtl/hpdcache_wbuf_send_sched.sv | 92 +++++++++
 tb/tb_hpdcache_wbuf_send_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared write-buffer entry state and time counter types.
package hpdcache_pkg;
  localparam int HPDCACHE_WBUF_TIMECNT_W = 3;
  typedef enum logic [1:0] {WBUF_FREE, WBUF_OPEN, WBUF_PEND, WBUF_SENT} wbuf_state_e;
  typedef logic [HPDCACHE_WBUF_TIMECNT_W-1:0] wbuf_timecnt_t;
endpackage

// File: rtl/hpdcache_wbuf_send_sched_if.sv
// hpdcache_wbuf_send_sched_if: alloc/hit/flush/send/ack bundle of the wbuf scheduler.
interface hpdcache_wbuf_send_sched_if #(
  parameter int N_ENTRIES     = 8,
  parameter int TIMECNT_WIDTH = 3,
  parameter int IDX_W         = $clog2(N_ENTRIES)
);
  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i;
  logic                     cfg_reset_timecnt_on_write_i;
  logic                     alloc_req_i;
  logic                     alloc_gnt_o;
  logic [IDX_W-1:0]         alloc_idx_o;
  logic                     hit_i;
  logic [IDX_W-1:0]         hit_idx_i;
  logic                     flush_all_i;
  logic                     send_valid_o;
  logic                     send_ready_i;
  logic [IDX_W-1:0]         send_idx_o;
  logic                     ack_i;
  logic [IDX_W-1:0]         ack_idx_i;
  logic                     full_o;
  logic                     empty_o;
  logic [N_ENTRIES-1:0]     open_vec_o;
  modport slave (
    input  cfg_threshold_i, cfg_reset_timecnt_on_write_i, alloc_req_i, hit_i, hit_idx_i,
           flush_all_i, send_ready_i, ack_i, ack_idx_i,
    output alloc_gnt_o, alloc_idx_o, send_valid_o, send_idx_o, full_o, empty_o, open_vec_o
  );
  modport master (
    output cfg_threshold_i, cfg_reset_timecnt_on_write_i, alloc_req_i, hit_i, hit_idx_i,
           flush_all_i, send_ready_i, ack_i, ack_idx_i,
    input  alloc_gnt_o, alloc_idx_o, send_valid_o, send_idx_o, full_o, empty_o, open_vec_o
  );
endinterface

// File: rtl/hpdcache_rr_pick.sv
// hpdcache_rr_pick: first set request scanning upward from ptr_i, wrapping.
module hpdcache_rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  assign valid_o = |req_i;
  always_comb begin
    idx_o = '0;
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = W'((int'(ptr_i) + k) % N);
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/hpdcache_wbuf_send_sched.sv
// hpdcache_wbuf_send_sched: wbuf entry lifecycle (alloc, aging, rr send, ack free).
module hpdcache_wbuf_send_sched
  import hpdcache_pkg::*;
#(
  parameter int N_ENTRIES     = 8,
  parameter int TIMECNT_WIDTH = HPDCACHE_WBUF_TIMECNT_W
) (
  input logic clk_i,
  input logic rst_ni,
  hpdcache_wbuf_send_sched_if.slave bus
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  wbuf_state_e              state_q [N_ENTRIES];
  wbuf_state_e              state_d [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_q   [N_ENTRIES];
  logic [TIMECNT_WIDTH-1:0] cnt_d   [N_ENTRIES];
  logic [IDX_W-1:0]         rr_q, rr_d, lock_idx_q, alloc_idx, pick_idx;
  logic                     lock_q, pick_vld, hs, gnt;
  logic [N_ENTRIES-1:0]     free_v, open_v, pend_v, sent_v, pick_gnt;
  always_comb begin
    free_v = '0;
    open_v = '0;
    pend_v = '0;
    sent_v = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_v[i] = state_q[i] == WBUF_FREE;
      open_v[i] = state_q[i] == WBUF_OPEN;
      pend_v[i] = state_q[i] == WBUF_PEND;
      sent_v[i] = state_q[i] == WBUF_SENT;
    end
  end
  always_comb begin
    alloc_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) if (free_v[i]) alloc_idx = IDX_W'(i);
  end
  // A stalled offer restarts the scan at the offered entry, so it stays first until accepted.
  hpdcache_rr_pick #(.N(N_ENTRIES), .W(IDX_W)) u_pick (
    .req_i  (pend_v),
    .ptr_i  (lock_q ? lock_idx_q : rr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_vld)
  );
  assign gnt  = bus.alloc_req_i & |free_v;
  assign hs   = pick_vld & bus.send_ready_i;
  assign rr_d = hs ? (pick_idx == IDX_W'(N_ENTRIES - 1) ? '0 : pick_idx + 1'b1) : rr_q;
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        WBUF_FREE: if (gnt && alloc_idx == IDX_W'(i)) begin
          state_d[i] = WBUF_OPEN;
          cnt_d[i]   = '0;
        end
        WBUF_OPEN: begin
          cnt_d[i] = &cnt_q[i] ? cnt_q[i] : cnt_q[i] + 1'b1;
          if (bus.flush_all_i) state_d[i] = WBUF_PEND;
          else if (bus.hit_i && bus.hit_idx_i == IDX_W'(i) && bus.cfg_reset_timecnt_on_write_i) cnt_d[i] = '0;
          else if (cnt_q[i] >= bus.cfg_threshold_i) state_d[i] = WBUF_PEND;
        end
        WBUF_PEND: if (hs && pick_gnt[i]) state_d[i] = WBUF_SENT;
        WBUF_SENT: if (bus.ack_i && bus.ack_idx_i == IDX_W'(i)) state_d[i] = WBUF_FREE;
        default: state_d[i] = WBUF_FREE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= WBUF_FREE;
        cnt_q[i]   <= '0;
      end
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      lock_q     <= pick_vld & ~bus.send_ready_i;
      lock_idx_q <= pick_idx;
    end
  assign bus.alloc_gnt_o  = gnt;
  assign bus.alloc_idx_o  = alloc_idx;
  assign bus.send_valid_o = pick_vld;
  assign bus.send_idx_o   = pick_idx;
  assign bus.full_o       = ~|free_v;
  assign bus.empty_o      = &free_v;
  assign bus.open_vec_o   = open_v;
  a_ack_sent: assert property (@(posedge clk_i) disable iff (!rst_ni) bus.ack_i |-> sent_v[bus.ack_idx_i]);
endmodule

// File: tb/tb_hpdcache_wbuf_send_sched.sv
// tb_hpdcache_wbuf_send_sched: directed scenario checks of the wbuf send scheduler.
module tb_hpdcache_wbuf_send_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  hpdcache_wbuf_send_sched_if #(.N_ENTRIES(8), .TIMECNT_WIDTH(3)) bus ();
  hpdcache_wbuf_send_sched #(.N_ENTRIES(8), .TIMECNT_WIDTH(3)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );
  always @(posedge clk)
    if (rst_n && bus.hit_i) assert (bus.open_vec_o[bus.hit_idx_i]) else $error("hit on non-open entry %0d", bus.hit_idx_i);
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    bus.alloc_req_i  = 1'b0;
    bus.hit_i        = 1'b0;
    bus.hit_idx_i    = '0;
    bus.flush_all_i  = 1'b0;
    bus.send_ready_i = 1'b0;
    bus.ack_i        = 1'b0;
    bus.ack_idx_i    = '0;
  endtask
  task automatic do_reset(input logic [2:0] thr, input logic row);
    idle();
    bus.cfg_threshold_i = thr;
    bus.cfg_reset_timecnt_on_write_i = row;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    idle();
    bus.cfg_threshold_i = 3'd3;
    bus.cfg_reset_timecnt_on_write_i = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    #1;
    checks++; if (bus.send_valid_o !== 1'b0) begin errs++; $display("FAIL reset_send_valid got %b want 0", bus.send_valid_o); end
    checks++; if (bus.alloc_gnt_o !== 1'b0) begin errs++; $display("FAIL reset_alloc_gnt got %b want 0", bus.alloc_gnt_o); end
    checks++; if (bus.full_o !== 1'b0) begin errs++; $display("FAIL reset_full got %b want 0", bus.full_o); end
    checks++; if (bus.empty_o !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", bus.empty_o); end
    checks++; if (bus.open_vec_o !== 8'h00) begin errs++; $display("FAIL reset_open_vec got %h want 00", bus.open_vec_o); end
    checks++; if (bus.send_idx_o !== 3'd0) begin errs++; $display("FAIL reset_send_idx got %0d want 0", bus.send_idx_o); end
    rst_n = 1'b1;
  endtask
  task automatic test_alloc_full();
    do_reset(3'd7, 1'b0);
    bus.alloc_req_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 3'(c))
        begin errs++; $display("FAIL alloc_seq c%0d got gnt=%b idx=%0d want gnt=1 idx=%0d", c, bus.alloc_gnt_o, bus.alloc_idx_o, c); end
      cyc();
    end
    #1;
    checks++; if (bus.full_o !== 1'b1 || bus.empty_o !== 1'b0) begin errs++; $display("FAIL alloc_full got full=%b empty=%b want 1 0", bus.full_o, bus.empty_o); end
    checks++; if (bus.alloc_gnt_o !== 1'b0) begin errs++; $display("FAIL alloc_ninth got gnt=%b want 0", bus.alloc_gnt_o); end
    checks++; if (bus.open_vec_o !== 8'hFF) begin errs++; $display("FAIL alloc_open_vec got %h want ff", bus.open_vec_o); end
    idle();
  endtask
  task automatic test_aging();
    do_reset(3'd3, 1'b0);
    bus.alloc_req_i = 1'b1;
    cyc();
    bus.alloc_req_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      bus.hit_i = (c == 2);
      #1;
      checks++; if (bus.send_valid_o !== (c == 5))
        begin errs++; $display("FAIL age_valid c%0d got %b want %b", c, bus.send_valid_o, c == 5); end
      if (c == 1) begin
        checks++; if (bus.open_vec_o !== 8'h01) begin errs++; $display("FAIL age_open got %h want 01", bus.open_vec_o); end
      end
      cyc();
    end
    bus.hit_i = 1'b0;
    #1;
    checks++; if (bus.send_valid_o !== 1'b1 || bus.send_idx_o !== 3'd0 || bus.open_vec_o !== 8'h00)
      begin errs++; $display("FAIL age_pend got valid=%b idx=%0d open=%h want 1 0 00", bus.send_valid_o, bus.send_idx_o, bus.open_vec_o); end
    idle();
  endtask
  task automatic test_hit_restart();
    do_reset(3'd3, 1'b1);
    bus.alloc_req_i = 1'b1;
    cyc();
    bus.alloc_req_i = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      bus.hit_i = (c <= 10) && c[0];
      #1;
      checks++; if (bus.send_valid_o !== (c == 14))
        begin errs++; $display("FAIL hit_valid c%0d got %b want %b", c, bus.send_valid_o, c == 14); end
      cyc();
    end
    idle();
  endtask
  task automatic test_rr_order();
    logic [2:0] exp_a [3] = '{3'd1, 3'd2, 3'd5};
    logic [2:0] exp_s [3] = '{3'd2, 3'd5, 3'd1};
    do_reset(3'd7, 1'b0);
    bus.alloc_req_i = 1'b1;
    repeat (5) cyc();
    bus.alloc_req_i = 1'b0;
    bus.flush_all_i = 1'b1;
    cyc();
    bus.flush_all_i = 1'b0;
    bus.send_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.send_valid_o !== 1'b1 || bus.send_idx_o !== 3'(k))
        begin errs++; $display("FAIL rr_first k%0d got valid=%b idx=%0d want 1 %0d", k, bus.send_valid_o, bus.send_idx_o, k); end
      cyc();
    end
    bus.send_ready_i = 1'b0;
    bus.ack_i = 1'b1;
    for (int a = 0; a < 3; a++) begin
      bus.ack_idx_i = 3'(a);
      cyc();
    end
    bus.ack_i = 1'b0;
    bus.alloc_req_i = 1'b1;
    repeat (2) cyc();
    bus.alloc_req_i = 1'b0;
    bus.flush_all_i = 1'b1;
    cyc();
    bus.flush_all_i = 1'b0;
    bus.send_ready_i = 1'b1;
    #1;
    checks++; if (bus.send_idx_o !== 3'd0) begin errs++; $display("FAIL rr_wrap got idx=%0d want 0", bus.send_idx_o); end
    cyc();
    cyc();
    bus.send_ready_i = 1'b0;
    bus.ack_i = 1'b1;
    bus.ack_idx_i = 3'd1;
    cyc();
    bus.ack_i = 1'b0;
    bus.alloc_req_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== exp_a[k])
        begin errs++; $display("FAIL rr_alloc k%0d got gnt=%b idx=%0d want 1 %0d", k, bus.alloc_gnt_o, bus.alloc_idx_o, exp_a[k]); end
      cyc();
    end
    bus.alloc_req_i = 1'b0;
    bus.flush_all_i = 1'b1;
    cyc();
    bus.flush_all_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.send_valid_o !== 1'b1 || bus.send_idx_o !== 3'd2)
        begin errs++; $display("FAIL rr_hold k%0d got valid=%b idx=%0d want 1 2", k, bus.send_valid_o, bus.send_idx_o); end
      cyc();
    end
    bus.send_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.send_valid_o !== 1'b1 || bus.send_idx_o !== exp_s[k])
        begin errs++; $display("FAIL rr_order k%0d got valid=%b idx=%0d want 1 %0d", k, bus.send_valid_o, bus.send_idx_o, exp_s[k]); end
      cyc();
    end
    bus.send_ready_i = 1'b0;
    #1;
    checks++; if (bus.send_valid_o !== 1'b0) begin errs++; $display("FAIL rr_done got valid=%b want 0", bus.send_valid_o); end
    idle();
  endtask
  task automatic test_flush_drain();
    do_reset(3'd7, 1'b0);
    bus.alloc_req_i = 1'b1;
    repeat (3) cyc();
    bus.alloc_req_i = 1'b0;
    bus.flush_all_i = 1'b1;
    #1;
    checks++; if (bus.open_vec_o !== 8'h07 || bus.send_valid_o !== 1'b0)
      begin errs++; $display("FAIL flush_pre got open=%h valid=%b want 07 0", bus.open_vec_o, bus.send_valid_o); end
    cyc();
    bus.flush_all_i = 1'b0;
    bus.send_ready_i = 1'b1;
    #1;
    checks++; if (bus.open_vec_o !== 8'h00 || bus.send_valid_o !== 1'b1)
      begin errs++; $display("FAIL flush_post got open=%h valid=%b want 00 1", bus.open_vec_o, bus.send_valid_o); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.send_idx_o !== 3'(k)) begin errs++; $display("FAIL flush_send k%0d got idx=%0d want %0d", k, bus.send_idx_o, k); end
      cyc();
    end
    bus.send_ready_i = 1'b0;
    bus.ack_i = 1'b1;
    for (int a = 0; a < 3; a++) begin
      bus.ack_idx_i = 3'(a);
      #1;
      checks++; if (bus.empty_o !== 1'b0) begin errs++; $display("FAIL drain_empty a%0d got %b want 0", a, bus.empty_o); end
      cyc();
    end
    bus.ack_i = 1'b0;
    #1;
    checks++; if (bus.empty_o !== 1'b1) begin errs++; $display("FAIL drain_final got empty=%b want 1", bus.empty_o); end
    idle();
  endtask
  task automatic test_ack_alloc();
    do_reset(3'd7, 1'b0);
    bus.alloc_req_i = 1'b1;
    repeat (8) cyc();
    bus.alloc_req_i = 1'b0;
    bus.flush_all_i = 1'b1;
    cyc();
    bus.flush_all_i = 1'b0;
    bus.send_ready_i = 1'b1;
    repeat (4) cyc();
    bus.send_ready_i = 1'b0;
    bus.ack_i = 1'b1;
    bus.ack_idx_i = 3'd3;
    bus.alloc_req_i = 1'b1;
    #1;
    checks++; if (bus.alloc_gnt_o !== 1'b0 || bus.full_o !== 1'b1)
      begin errs++; $display("FAIL ack_same got gnt=%b full=%b want 0 1", bus.alloc_gnt_o, bus.full_o); end
    cyc();
    bus.ack_i = 1'b0;
    #1;
    checks++; if (bus.alloc_gnt_o !== 1'b1 || bus.alloc_idx_o !== 3'd3 || bus.full_o !== 1'b0)
      begin errs++; $display("FAIL ack_next got gnt=%b idx=%0d full=%b want 1 3 0", bus.alloc_gnt_o, bus.alloc_idx_o, bus.full_o); end
    cyc();
    idle();
  endtask
  initial begin
    test_reset();
    test_alloc_full();
    test_aging();
    test_hit_restart();
    test_rr_order();
    test_flush_drain();
    test_ack_alloc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
